fs_ds_inst_queue: RTL
=====================

// Module: fs_ds_inst_queue
// PURPOSE
//   Instruction buffer between the IF stage and the ID stage. Decouples instruction fetch from decode stalls.
//   Accepts fetched-instruction bundles {tlb_refill, bd, ex, excode, inst, pc} from IF using a valid/allowin
//   handshake, stores them in FIFO order and presents the oldest one to ID using the same handshake.
//   A flush from WB (exception, eret or refetch) discards all contents.
// PARAMETERS
//   DEPTH   4   number of entries; must be a power of 2 and >= 2
//   BUS_WD  72  bundle width; equals FS_TO_DS_BUS_WD
//   PTR_W   2   log2(DEPTH)
// PORTS
//   clk             in   1          clock
//   reset           in   1          synchronous, active-high reset
//   flush           in   1          ws_ex | ws_eret | start_refetch
//   fs_to_iq_valid  in   1          IF has a valid bundle
//   fs_to_iq_bus    in   BUS_WD     IF bundle; bit 69 = fs_ex
//   iq_allowin      out  1          queue accepts a bundle this cycle (goes to IF as ds_allowin)
//   iq_to_ds_valid  out  1          head entry is valid for ID
//   iq_to_ds_bus    out  BUS_WD     head entry contents
//   ds_allowin      in   1          ID accepts a bundle this cycle
//   iq_count        out  PTR_W+1    number of occupied entries, 0..DEPTH
//   iq_ex_block     out  1          queue is blocked after accepting an exception bundle
// BEHAVIOUR
//   Reset values (next edge after reset=1):
//     - rd_ptr, wr_ptr, iq_count = 0; ex_block = 0.
//     - Outputs: iq_to_ds_valid = 0, iq_allowin = 1, iq_ex_block = 0.
//     - Storage is not reset; iq_to_ds_bus is don't-care while valid = 0.
//     - Reset asserted mid-operation discards all entries, the same as flush.
//   Handshake:
//     - enq = fs_to_iq_valid & iq_allowin & ~flush
//     - deq = iq_to_ds_valid & ds_allowin
//     - iq_allowin = ~ex_block & (iq_count != DEPTH | ds_allowin)
//       When full and ID is dequeuing, a simultaneous enqueue is allowed.
//       Do not gate iq_allowin with flush; IF drops its own bundle on flush.
//     - iq_to_ds_valid = (iq_count != 0) & ~flush
//   Latency:
//     - No bypass. A bundle enqueued at edge N is visible to ID starting in cycle N+1. Minimum latency is 1 cycle.
//     - Throughput is 1 bundle per cycle in steady state, including at full and at count = 1.
//   Storage: a DEPTH x BUS_WD register array.
//     - wr_ptr increments on enq and rd_ptr increments on deq; both wrap modulo DEPTH (natural PTR_W overflow).
//     - iq_count += enq - deq; simultaneous enq and deq leaves the count unchanged.
//     - iq_to_ds_bus = mem[rd_ptr].
//   Exception blocking (ex_block register):
//     - Set on an enq whose fs_to_iq_bus[69] = 1.
//     - While set: iq_allowin = 0, and existing entries still drain to ID.
//     - Cleared only by flush or reset; the WB flush that follows the exception reopens the queue.
//   Flush (takes priority over every other update in the same cycle):
//     - Next state: pointers = 0, count = 0, ex_block = 0.
//     - Any enq or deq in the flush cycle is suppressed.
//     - iq_to_ds_valid = 0 during the flush cycle.
//   Boundary conditions:
//     - Empty with deq attempted: impossible, because valid = 0.
//     - Full with no deq: iq_allowin = 0 and IF holds its bundle.
//     - Full with flush and fs valid: the bundle is dropped and the queue is empty next cycle.
// TESTING
//   1. Reset, then enqueue pc 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c with ds_allowin = 0.
//      -> count = 4 and iq_allowin = 0. Then ds_allowin = 1 -> pcs leave in order, one per cycle.
//   2. Full queue with fs valid and ds_allowin = 1 in the same cycle -> count stays 4, the head advances,
//      and the new pc lands at the tail.
//   3. Stream 10 bundles with ds_allowin toggling 1,0,1,... -> output pc order matches input order
//      across pointer wrap, with no loss and no duplication.
//   4. Enqueue a bundle with ex = 1 (excode TLBL) followed by 2 more fs-valid cycles.
//      -> iq_allowin = 0 after it, only entries up to the ex bundle drain, and iq_ex_block = 1.
//      Then flush -> iq_ex_block = 0 and iq_allowin = 1.
//   5. 3 entries held, then flush = 1 with fs valid and ds_allowin = 1.
//      -> iq_to_ds_valid = 0 in that cycle and count = 0 in the next; the following enq appears after 1 cycle.
//   6. reset asserted with 2 entries held -> next cycle valid = 0, count = 0, iq_allowin = 1.

Source files
------------

// File: rtl/fs_ds_inst_queue_if.sv
// Valid/allowin handshake bundle between IF, the instruction queue and ID.
// The queue attaches through the slave modport; the fetch/decode side drives through master.
interface fs_ds_inst_queue_if #(
    parameter int BUS_WD = 72
);
    logic              fs_to_iq_valid;
    logic [BUS_WD-1:0] fs_to_iq_bus;
    logic              iq_allowin;
    logic              iq_to_ds_valid;
    logic [BUS_WD-1:0] iq_to_ds_bus;
    logic              ds_allowin;

    modport master (
        output fs_to_iq_valid, fs_to_iq_bus, ds_allowin,
        input  iq_allowin, iq_to_ds_valid, iq_to_ds_bus
    );

    modport slave (
        input  fs_to_iq_valid, fs_to_iq_bus, ds_allowin,
        output iq_allowin, iq_to_ds_valid, iq_to_ds_bus
    );
endinterface

// File: rtl/fs_ds_inst_queue.sv
// FIFO of fetched-instruction bundles between IF and ID, flushed by WB.
// Accepting an exception bundle closes the input until the following flush.
module fs_ds_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int BUS_WD = 72,
    parameter int PTR_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    fs_ds_inst_queue_if.slave  iq,
    output logic [PTR_W:0]     iq_count,
    output logic               iq_ex_block
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam int             EX_BIT   = 69;

    logic [BUS_WD-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              ex_block;
    logic              enq;
    logic              deq;

    // A full queue still accepts when ID drains the head in the same cycle.
    assign iq.iq_allowin     = ~ex_block & ((iq_count != FULL_CNT) | iq.ds_allowin);
    assign iq.iq_to_ds_valid = (iq_count != '0) & ~flush;
    assign iq.iq_to_ds_bus   = mem[rd_ptr];
    assign iq_ex_block       = ex_block;

    assign enq = iq.fs_to_iq_valid & iq.iq_allowin & ~flush;
    assign deq = iq.iq_to_ds_valid & iq.ds_allowin;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            iq_count <= '0;
            ex_block <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                iq_count <= iq_count + (PTR_W + 1)'(1);
            end else if (deq && !enq) begin
                iq_count <= iq_count - (PTR_W + 1)'(1);
            end
            if (enq && iq.fs_to_iq_bus[EX_BIT]) begin
                ex_block <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= iq.fs_to_iq_bus;
        end
    end
endmodule
